// File: rtl/rx_flag_controller.sv
// rx_flag_controller: receive-side control stage feeding the flags register
// file of the gpp_txrx node. Accepts one-word network messages, writes each
// payload into a per-source receive buffer slot, pulses the rx flag write
// port to mark the message received, and pulses the rtr write port to clear
// it when the processor acknowledges the message.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   net_valid/net_ready        network handshake
//   net_src, net_data          message source index and payload
//   buf_write_enable,
//   buf_address,
//   buf_write_data             receive buffer write port (slot = source)
//   rx_write_enable, address_1 flags file set strobe and index
//   rtr_write_enable,address_2 flags file clear strobe and index
//   cpu_ack, cpu_ack_src       processor acknowledge pulse and source
//   pending                    local copy of flag state, one bit per slot
//   stall_cycles               saturating count of cycles spent stalled
module rx_flag_controller #(
    parameter int ADDR_WIDTH      = 1,
    parameter int DATA_WIDTH      = 16,
    parameter int STALL_CNT_WIDTH = 16,
    localparam int NODES          = 2 ** ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       net_valid,
    output logic                       net_ready,
    input  logic [ADDR_WIDTH-1:0]      net_src,
    input  logic [DATA_WIDTH-1:0]      net_data,
    output logic                       buf_write_enable,
    output logic [ADDR_WIDTH-1:0]      buf_address,
    output logic [DATA_WIDTH-1:0]      buf_write_data,
    output logic                       rx_write_enable,
    output logic [ADDR_WIDTH-1:0]      address_1,
    output logic                       rtr_write_enable,
    output logic [ADDR_WIDTH-1:0]      address_2,
    input  logic                       cpu_ack,
    input  logic [ADDR_WIDTH-1:0]      cpu_ack_src,
    output logic [NODES-1:0]           pending,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STALL,
        WRITE,
        FLAG
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      src_q, src_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       net_ready_q, net_ready_d;
    logic                       buf_we_q, buf_we_d;
    logic [ADDR_WIDTH-1:0]      buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0]      buf_data_q, buf_data_d;
    logic                       rx_we_q, rx_we_d;
    logic [ADDR_WIDTH-1:0]      addr1_q, addr1_d;
    logic                       rtr_we_q, rtr_we_d;
    logic [ADDR_WIDTH-1:0]      addr2_q, addr2_d;
    logic [NODES-1:0]           pending_q, pending_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        data_d     = data_q;
        buf_we_d   = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        rx_we_d    = 1'b0;
        addr1_d    = addr1_q;
        stall_d    = stall_q;
        pending_d  = pending_q;

        unique case (state_q)
            IDLE: begin
                // net_ready_q is what the network saw this cycle
                if (net_valid && net_ready_q) begin
                    src_d   = net_src;
                    data_d  = net_data;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = pending_q[src_q] ? STALL : WRITE;
            end
            STALL: begin
                if (stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
                if (!pending_q[src_q]) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                buf_we_d   = 1'b1;
                buf_addr_d = src_q;
                buf_data_d = data_q;
                state_d    = FLAG;
            end
            FLAG: begin
                rx_we_d = 1'b1;
                addr1_d = src_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered from the next state so that it drops on the
        // same edge that accepts a message.
        net_ready_d = (state_d == IDLE);

        // An ack only counts against a slot that is already pending, so an
        // ack racing the set of the same slot is dropped and the set wins.
        rtr_we_d = cpu_ack && pending_q[cpu_ack_src];
        addr2_d  = rtr_we_d ? cpu_ack_src : addr2_q;
        if (rtr_we_d) begin
            pending_d[cpu_ack_src] = 1'b0;
        end
        if (state_q == FLAG) begin
            pending_d[src_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            data_q      <= '0;
            net_ready_q <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            rx_we_q     <= 1'b0;
            addr1_q     <= '0;
            rtr_we_q    <= 1'b0;
            addr2_q     <= '0;
            pending_q   <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            data_q      <= data_d;
            net_ready_q <= net_ready_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            rx_we_q     <= rx_we_d;
            addr1_q     <= addr1_d;
            rtr_we_q    <= rtr_we_d;
            addr2_q     <= addr2_d;
            pending_q   <= pending_d;
            stall_q     <= stall_d;
        end
    end

    assign net_ready        = net_ready_q;
    assign buf_write_enable = buf_we_q;
    assign buf_address      = buf_addr_q;
    assign buf_write_data   = buf_data_q;
    assign rx_write_enable  = rx_we_q;
    assign address_1        = addr1_q;
    assign rtr_write_enable = rtr_we_q;
    assign address_2        = addr2_q;
    assign pending          = pending_q;
    assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_rx_flag_controller.sv
// Testbench for rx_flag_controller: directed sequence with a scoreboard of
// expected buffer, rx and rtr strobes checked as the DUT emits them.
module tb_rx_flag_controller;

    logic        clk;
    logic        rst_n;
    logic        net_valid;
    logic        net_ready;
    logic [0:0]  net_src;
    logic [15:0] net_data;
    logic        buf_write_enable;
    logic [0:0]  buf_address;
    logic [15:0] buf_write_data;
    logic        rx_write_enable;
    logic [0:0]  address_1;
    logic        rtr_write_enable;
    logic [0:0]  address_2;
    logic        cpu_ack;
    logic [0:0]  cpu_ack_src;
    logic [1:0]  pending;
    logic [15:0] stall_cycles;

    rx_flag_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .net_valid        (net_valid),
        .net_ready        (net_ready),
        .net_src          (net_src),
        .net_data         (net_data),
        .buf_write_enable (buf_write_enable),
        .buf_address      (buf_address),
        .buf_write_data   (buf_write_data),
        .rx_write_enable  (rx_write_enable),
        .address_1        (address_1),
        .rtr_write_enable (rtr_write_enable),
        .address_2        (address_2),
        .cpu_ack          (cpu_ack),
        .cpu_ack_src      (cpu_ack_src),
        .pending          (pending),
        .stall_cycles     (stall_cycles)
    );

    typedef struct {
        int          cyc;
        logic [0:0]  a;
        logic [15:0] d;
    } ev_t;

    ev_t q_buf[$];
    ev_t q_rx[$];
    ev_t q_rtr[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_msg(input logic [0:0] s, input logic [15:0] d,
                           input int a, input int lat);
        q_buf.push_back('{a + lat - 1, s, d});
        q_rx.push_back('{a + lat, s, 16'h0});
    endtask

    task automatic exp_rtr(input logic [0:0] s, input int c);
        q_rtr.push_back('{c, s, 16'h0});
    endtask

    // Present one message as soon as ready; a = cycle of the accepting edge.
    task automatic send(input logic [0:0] s, input logic [15:0] d,
                        output int a);
        int n;
        n = 0;
        while (!net_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (net_ready === 1'b1) else begin
            bad++;
            $error("FAIL ready_wait got=%b exp=1", net_ready);
        end
        net_src   = s;
        net_data  = d;
        net_valid = 1'b1;
        a = cyc + 1;
        @(negedge clk);
        net_valid = 1'b0;
        net_src   = 1'($urandom);
        net_data  = 16'($urandom);
    endtask

    // Scoreboard side: every strobe must match the head of its queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (buf_write_enable) begin
                total++;
                assert (q_buf.size() != 0) else begin
                    bad++;
                    $error("FAIL buf_unexpected got=1 exp=0 cyc=%0d", cyc);
                end
                if (q_buf.size() != 0) begin
                    e = q_buf.pop_front();
                    total++;
                    assert (cyc == e.cyc && buf_address === e.a &&
                            buf_write_data === e.d) else begin
                        bad++;
                        $error("FAIL buf got=%0d/%0h/%0h exp=%0d/%0h/%0h",
                               cyc, buf_address, buf_write_data,
                               e.cyc, e.a, e.d);
                    end
                end
            end
            if (rx_write_enable) begin
                total++;
                assert (q_rx.size() != 0) else begin
                    bad++;
                    $error("FAIL rx_unexpected got=1 exp=0 cyc=%0d", cyc);
                end
                if (q_rx.size() != 0) begin
                    e = q_rx.pop_front();
                    total++;
                    assert (cyc == e.cyc && address_1 === e.a) else begin
                        bad++;
                        $error("FAIL rx got=%0d/%0h exp=%0d/%0h",
                               cyc, address_1, e.cyc, e.a);
                    end
                end
            end
            if (rtr_write_enable) begin
                total++;
                assert (q_rtr.size() != 0) else begin
                    bad++;
                    $error("FAIL rtr_unexpected got=1 exp=0 cyc=%0d", cyc);
                end
                if (q_rtr.size() != 0) begin
                    e = q_rtr.pop_front();
                    total++;
                    assert (cyc == e.cyc && address_2 === e.a) else begin
                        bad++;
                        $error("FAIL rtr got=%0d/%0h exp=%0d/%0h",
                               cyc, address_2, e.cyc, e.a);
                    end
                end
            end
        end
    end

    initial begin
        int a;
        int b;
        int c;
        net_valid   = 1'b0;
        net_src     = 1'b0;
        net_data    = 16'h0;
        cpu_ack     = 1'b0;
        cpu_ack_src = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(net_ready), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        chk("rst_strobes", 32'({buf_write_enable, rx_write_enable,
                                rtr_write_enable}), 32'h0);
        chk("rst_outs", 32'({buf_address, buf_write_data, address_1,
                             address_2}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(net_ready), 32'h1);
        chk("rel_pending", 32'(pending), 32'h0);

        // Single message to slot 1
        send(1'b1, 16'hA5A5, a);
        exp_msg(1'b1, 16'hA5A5, a, 3);
        @(negedge clk);
        chk("msg_busy", 32'(net_ready), 32'h0);
        repeat (2) @(negedge clk);
        chk("msg_pending", 32'(pending), 32'h2);
        chk("msg_ready_back", 32'(net_ready), 32'h1);

        // Ack slot 1, then a repeated ack that must be ignored
        cpu_ack = 1'b1; cpu_ack_src = 1'b1; exp_rtr(1'b1, cyc + 1);
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("ack_pending", 32'(pending), 32'h0);
        cpu_ack = 1'b1; cpu_ack_src = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("ack2_pending", 32'(pending), 32'h0);
        @(negedge clk);

        // Stall: two messages to slot 0, ack released during the stall
        send(1'b0, 16'h1111, a);
        exp_msg(1'b0, 16'h1111, a, 3);
        repeat (3) @(negedge clk);
        chk("st1_pending", 32'(pending), 32'h1);
        send(1'b0, 16'h2222, b);
        exp_msg(1'b0, 16'h2222, b, 8);
        exp_rtr(1'b0, b + 5);
        repeat (3) @(negedge clk);
        chk("st_ready_low", 32'(net_ready), 32'h0);
        @(negedge clk);
        cpu_ack = 1'b1; cpu_ack_src = 1'b0;
        @(negedge clk);
        cpu_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("st_cycles", 32'(stall_cycles), 32'd5);
        chk("st_pending", 32'(pending), 32'h1);

        // Ack of slot 0 racing its own set is dropped
        c = cyc + 1; cpu_ack = 1'b1; cpu_ack_src = 1'b0; exp_rtr(1'b0, c);
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("simA_clear", 32'(pending), 32'h0);
        send(1'b0, 16'h3333, a);
        exp_msg(1'b0, 16'h3333, a, 3);
        repeat (2) @(negedge clk);
        cpu_ack = 1'b1; cpu_ack_src = 1'b0;
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("simA_pending", 32'(pending), 32'h1);
        @(negedge clk);
        chk("simA_hold", 32'(pending), 32'h1);

        // Ack of slot 1 coinciding with the set of slot 0
        c = cyc + 1; cpu_ack = 1'b1; cpu_ack_src = 1'b0; exp_rtr(1'b0, c);
        @(negedge clk);
        cpu_ack = 1'b0;
        send(1'b1, 16'h4444, a);
        exp_msg(1'b1, 16'h4444, a, 3);
        repeat (3) @(negedge clk);
        chk("simB_pre", 32'(pending), 32'h2);
        send(1'b0, 16'h5555, a);
        exp_msg(1'b0, 16'h5555, a, 3);
        repeat (2) @(negedge clk);
        cpu_ack = 1'b1; cpu_ack_src = 1'b1; exp_rtr(1'b1, a + 3);
        @(negedge clk);
        cpu_ack = 1'b0;
        chk("simB_both", 32'({rx_write_enable, rtr_write_enable}), 32'h3);
        chk("simB_pending", 32'(pending), 32'h1);

        // Reset while the message is in WRITE: nothing may be emitted
        send(1'b1, 16'h6666, a);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_pending", 32'(pending), 32'h0);
        chk("mid_ready", 32'(net_ready), 32'h1);
        chk("mid_stall", 32'(stall_cycles), 32'h0);
        send(1'b1, 16'h7777, a);
        exp_msg(1'b1, 16'h7777, a, 3);
        repeat (3) @(negedge clk);
        chk("post_pending", 32'(pending), 32'h2);

        repeat (4) @(negedge clk);
        chk("q_buf_empty", 32'(q_buf.size()), 32'h0);
        chk("q_rx_empty", 32'(q_rx.size()), 32'h0);
        chk("q_rtr_empty", 32'(q_rtr.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_flag_controller.md
Name: rx_flag_controller

Overview:
- Receive-side control stage sitting directly upstream of the flags register file in the gpp_txrx node.
- Accepts one-word messages from the photonic network interface and stores each payload into a per-source receive buffer slot.
- Drives the flags register file: a one-cycle pulse on the rx write port sets the source's "message received" flag, and a one-cycle pulse on the rtr write port clears it (ready-to-receive) when the processor acknowledges the message.
- Back-pressures the network while a source's previous message is still unread.

Parameters:
ADDR_WIDTH, 1, width of the source/node index; NODES = 2**ADDR_WIDTH slots.
DATA_WIDTH, 16, message payload width.
STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
net_valid  input  1  network presents a message.
net_ready  output  1  controller can accept a message this cycle.
net_src  input  ADDR_WIDTH  source node index of the message.
net_data  input  DATA_WIDTH  message payload.
buf_write_enable  output  1  receive buffer write strobe.
buf_address  output  ADDR_WIDTH  receive buffer slot (= source index).
buf_write_data  output  DATA_WIDTH  payload written to the slot.
rx_write_enable  output  1  flags register file set strobe.
address_1  output  ADDR_WIDTH  flag index to set.
rtr_write_enable  output  1  flags register file clear strobe.
address_2  output  ADDR_WIDTH  flag index to clear.
cpu_ack  input  1  one-cycle pulse: processor consumed a message.
cpu_ack_src  input  ADDR_WIDTH  source index being acknowledged.
pending  output  NODES  internal copy of flag state; bit i = slot i holds an unread message.
stall_cycles  output  STALL_CNT_WIDTH  saturating count of cycles spent in STALL.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0 (net_ready=0, all strobes 0, addresses 0, buf_write_data 0, pending 0, stall_cycles 0).
  - Latched source and data registers cleared.
  - On the first clock after release, net_ready=1.
- Reset asserted mid-operation aborts any in-flight message; no strobe is emitted for it.
- All outputs are registered.
- FSM states:
  - IDLE: net_ready=1. On net_valid&&net_ready, latch net_src/net_data and go to CHECK.
  - CHECK: net_ready=0. If pending[src]=0, go to WRITE; otherwise go to STALL.
  - STALL: net_ready=0. stall_cycles increments each cycle in this state and saturates at all-ones (no wrap). Leave for WRITE in the cycle after pending[src] clears.
  - WRITE: buf_write_enable=1 for exactly one cycle, with buf_address=src and buf_write_data=data. Next state is FLAG.
  - FLAG: rx_write_enable=1 for exactly one cycle with address_1=src. pending[src] is set at the end of the cycle. Next state is IDLE.
- Latency, accept to rx_write_enable (no stall): accept edge, then CHECK, WRITE, FLAG. rx_write_enable is high 3 cycles after the accepting edge. Sustained throughput is one message per 4 cycles.
- Ack path runs independently of the FSM:
  - cpu_ack sampled high with pending[cpu_ack_src]=1 produces rtr_write_enable=1 with address_2=cpu_ack_src on the next cycle, and clears pending[cpu_ack_src] on that same edge.
  - Back-to-back acks to different sources yield back-to-back rtr pulses.
  - An ack to a non-pending source is ignored: no pulse, no state change.
- Simultaneous events:
  - Ack to index k in the same cycle FLAG sets k: the ack is ignored (k not yet pending); set wins.
  - Ack to index k while STALL waits on k: the clear happens, and WRITE follows the next cycle.
  - rx_write_enable and rtr_write_enable may be high in the same cycle only for different indices.
- address_1, address_2 and buf_address hold their last value when their strobe is low.
- net_src/net_data are ignored when net_valid&&net_ready is false.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → net_ready=1 next cycle; pending=2'b00; all strobes 0; stall_cycles=0.
- Single message: src=1, data=16'hA5A5, net_valid pulsed in IDLE → buf_write_enable with buf_address=1 and data A5A5 2 cycles after accept; rx_write_enable with address_1=1 at 3 cycles; pending=2'b10.
- Ack: cpu_ack with src=1 → rtr_write_enable with address_2=1 next cycle; pending=2'b00. A second ack to src=1 gives no pulse.
- Stall: send src=0 twice without ack → second message stalls and net_ready stays 0. Ack src=0 after 5 stall cycles → stall_cycles=5; second message written and its flag set; final pending=2'b01.
- Simultaneous: ack src=0 in the same cycle FLAG sets src=0 → no rtr pulse; pending[0]=1. Ack src=1 (pending) while FLAG sets src=0 → rx and rtr pulses in the same cycle; pending=2'b01.
- Mid-operation reset: assert rst_n=0 during WRITE → no rx_write_enable; pending=0; FSM in IDLE after release.
